// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU bus arbiter: port ids, FSM encoding, starvation counter sizing.
package cpu_bus_arbiter_pkg;

    localparam int unsigned NUM_PORTS            = 3;
    localparam int unsigned CNT_W                = 4;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

    typedef logic [1:0]       port_id_t;
    typedef logic [CNT_W-1:0] starve_cnt_t;

    localparam port_id_t PORT_A = 2'd0;
    localparam port_id_t PORT_B = 2'd1;
    localparam port_id_t PORT_C = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusy    = 2'd1,
        StRelease = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_bus_arbiter_select.sv
// Combinational winner selection: starved ports first, then fixed priority B > A > C.
module cpu_bus_arbiter_select
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic [NUM_PORTS-1:0]            request,
    input  logic [NUM_PORTS-1:0][CNT_W-1:0] starve,
    output logic                            grant_valid,
    output port_id_t                        grant_id
);

    logic [NUM_PORTS-1:0] starved;

    function automatic port_id_t pick(input logic [NUM_PORTS-1:0] mask);
        port_id_t id;
        id = PORT_B;
        if (mask[PORT_B]) begin
            id = PORT_B;
        end else if (mask[PORT_A]) begin
            id = PORT_A;
        end else if (mask[PORT_C]) begin
            id = PORT_C;
        end
        return id;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            starved[i] = request[i] && (starve[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    always_comb begin
        grant_valid = |request;
        grant_id    = (|starved) ? pick(starved) : pick(request);
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the external CPU bus between fetch (A), memory stage (B) and DMA (C).
// One transaction in flight; a winner must drop its request before the next arbitration.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    input  logic        i_pa_request,
    output logic        o_pa_ready,
    input  logic [31:0] i_pa_address,
    output logic [31:0] o_pa_rdata,
    input  logic        i_pb_rw,
    input  logic        i_pb_request,
    output logic        o_pb_ready,
    input  logic [31:0] i_pb_address,
    input  logic [31:0] i_pb_wdata,
    output logic [31:0] o_pb_rdata,
    input  logic        i_pc_rw,
    input  logic        i_pc_request,
    output logic        o_pc_ready,
    input  logic [31:0] i_pc_address,
    input  logic [31:0] i_pc_wdata,
    output logic [31:0] o_pc_rdata
);

    state_t                          state_q;
    port_id_t                        winner_q;
    logic [NUM_PORTS-1:0][CNT_W-1:0] starve_q;
    logic [NUM_PORTS-1:0]            request;
    logic                            grant_valid;
    port_id_t                        grant_id;

    assign request = {i_pc_request, i_pb_request, i_pa_request};

    cpu_bus_arbiter_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .request    (request),
        .starve     (starve_q),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= StIdle;
            winner_q      <= PORT_A;
            starve_q      <= '0;
            o_bus_rw      <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_pa_ready    <= 1'b0;
            o_pb_ready    <= 1'b0;
            o_pc_ready    <= 1'b0;
            o_pa_rdata    <= '0;
            o_pb_rdata    <= '0;
            o_pc_rdata    <= '0;
        end else begin
            o_pa_ready <= 1'b0;
            o_pb_ready <= 1'b0;
            o_pc_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        winner_q      <= grant_id;
                        o_bus_request <= 1'b1;
                        state_q       <= StBusy;
                        case (grant_id)
                            PORT_A: begin
                                o_bus_address <= i_pa_address;
                                o_bus_rw      <= 1'b0;
                                o_bus_wdata   <= '0;
                            end
                            PORT_B: begin
                                o_bus_address <= i_pb_address;
                                o_bus_rw      <= i_pb_rw;
                                o_bus_wdata   <= i_pb_wdata;
                            end
                            default: begin
                                o_bus_address <= i_pc_address;
                                o_bus_rw      <= i_pc_rw;
                                o_bus_wdata   <= i_pc_wdata;
                            end
                        endcase
                        // Losers that are still pending age; everyone else restarts.
                        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                            if (!request[i] || port_id_t'(i) == grant_id) begin
                                starve_q[i] <= '0;
                            end else if (starve_q[i] != CNT_W'(STARVE_LIMIT)) begin
                                starve_q[i] <= starve_q[i] + CNT_W'(1);
                            end
                        end
                    end
                end
                StBusy: begin
                    if (i_bus_ready) begin
                        o_bus_request <= 1'b0;
                        state_q       <= StRelease;
                        case (winner_q)
                            PORT_A: begin
                                o_pa_ready <= 1'b1;
                                if (!o_bus_rw) o_pa_rdata <= i_bus_rdata;
                            end
                            PORT_B: begin
                                o_pb_ready <= 1'b1;
                                if (!o_bus_rw) o_pb_rdata <= i_bus_rdata;
                            end
                            default: begin
                                o_pc_ready <= 1'b1;
                                if (!o_bus_rw) o_pc_rdata <= i_bus_rdata;
                            end
                        endcase
                    end
                end
                StRelease: begin
                    if (!request[winner_q]) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Shares the single external CPU bus between three requesters: instruction fetch (port A), data memory stage (port B) and a DMA/debug master (port C). Sits between the pipeline's fetch/memory stages plus the DMA engine and the system bus. Fixed priority B > A > C, with a per-port starvation counter forcing service of any port that keeps losing. One bus transaction is in flight at a time; each port sees a request/ready handshake identical to the external bus.

## Interface
- STARVE_LIMIT, 8: consecutive lost arbitrations after which a pending port is force-granted (1..15).
- i_clock  in  1  CPU clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- o_bus_rw  out  1  1 = write, 0 = read.
- o_bus_request  out  1  external request, held until i_bus_ready.
- i_bus_ready  in  1  external transfer complete.
- o_bus_address  out  32  external address.
- i_bus_rdata  in  32  external read data.
- o_bus_wdata  out  32  external write data.
- i_pa_request  in  1  fetch request (read only).
- o_pa_ready  out  1  fetch done pulse.
- i_pa_address  in  32  fetch address.
- o_pa_rdata  out  32  fetch read data.
- i_pb_rw, i_pb_request  in  1  memory-stage direction, request.
- o_pb_ready  out  1  memory-stage done pulse.
- i_pb_address, i_pb_wdata  in  32  memory-stage address, write data.
- o_pb_rdata  out  32  memory-stage read data.
- i_pc_rw, i_pc_request, o_pc_ready, i_pc_address, i_pc_wdata, o_pc_rdata: as port B, for DMA.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: if any i_px_request, choose winner; register winner id, address, rw (port A forced 0), wdata; go BUSY.
- Winner selection: any pending port whose starvation counter == STARVE_LIMIT wins (ties B > A > C); else B > A > C.
- Starvation counters (4-bit, saturating at STARVE_LIMIT): on each IDLE arbitration, a pending non-winner increments; the winner clears; non-pending ports clear.
- BUSY: o_bus_request = 1 with registered address/rw/wdata stable. On i_bus_ready: latch i_bus_rdata into winner's o_px_rdata (reads only; writes leave it unchanged), pulse winner's o_px_ready for one cycle, go RELEASE.
- RELEASE: wait until winner's i_px_request is low, then IDLE. Prevents re-serving a request still held from the previous handshake.
- Request dropped during BUSY (protocol violation): bus transaction completes normally, ready still pulsed, RELEASE exits next cycle.
- i_bus_ready outside BUSY ignored.
- o_px_rdata holds last value until next read completion for that port.

## Timing
- Reset: state IDLE; o_bus_request, o_bus_rw, all o_px_ready = 0; o_bus_address, o_bus_wdata, all o_px_rdata = 0; counters 0.
- All outputs registered except none; no combinational path from i_px_* to o_bus_*.
- Request seen in IDLE at edge n → o_bus_request high after edge n.
- i_bus_ready high at edge m → o_bus_request low and o_px_ready high after edge m, rdata valid same cycle.
- Minimum round trip: request to ready pulse = 2 cycles when bus readies on first BUSY cycle.
- Back-to-back: requester drops request the cycle after ready; earliest next grant 2 cycles after ready pulse (RELEASE, IDLE).
- Reset asserted mid-transaction: outputs go to reset values immediately; in-flight transaction abandoned, no ready pulse.

## Structure
- Shared CPU package: port-id constants (PORT_A=0, PORT_B=1, PORT_C=2), state encoding constants, STARVE_LIMIT default.
- One natural sub-module: cpu_bus_arbiter_select (combinational winner selection from requests + counters), reused by other arbiters.
- Single always block for FSM/registers plus the select instance.

## Test plan
- Single fetch: A requests 0x00000100, bus ready after 3 cycles with 0xDEADBEEF → o_bus_rw=0, o_pa_rdata=0xDEADBEEF, one-cycle o_pa_ready, B/C ready stay 0.
- Simultaneous A and B (B write 0x2000, data 0x12345678) → B served first with o_bus_rw=1, o_bus_wdata=0x12345678; A served next; o_pb_rdata unchanged.
- Starvation: B and A requesting continuously, C held from cycle 0 with STARVE_LIMIT=8 → C granted at its 9th arbitration, then counter 0.
- Held request: A keeps request high 4 cycles after o_pa_ready → exactly one bus transaction; next only after drop.
- Reset during BUSY with o_bus_request=1 → o_bus_request falls without clock edge, no o_px_ready; after release, pending B served normally.
- Stray i_bus_ready pulses in IDLE → no state change, no ready pulses, rdata unchanged.
